// File: rtl/arm_multi_pkg.sv
// Shared types and encodings for the multicycle ARM control sequencer.
// Holds the state enum, datapath select codes and condition helpers.
package arm_multi_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;
  localparam logic [2:0] ALU_CMP = 3'b110;
  localparam logic [2:0] ALU_TST = 3'b111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;

  function automatic logic cond_holds(
    input logic [3:0] cond,
    input logic [3:0] nzcv
  );
    logic n, z, c, v;
    logic ok;
    {n, z, c, v} = nzcv;
    unique case (cond)
      COND_EQ: ok = z;
      COND_NE: ok = !z;
      COND_CS: ok = c;
      COND_CC: ok = !c;
      COND_MI: ok = n;
      COND_PL: ok = !n;
      COND_VS: ok = v;
      COND_VC: ok = !v;
      COND_HI: ok = c & !z;
      COND_LS: ok = !c | z;
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = !z & (n == v);
      COND_LE: ok = z | (n != v);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] alu_decode(
    input logic [3:0] cmd
  );
    logic [2:0] a;
    unique case (cmd)
      CMD_ADD: a = ALU_ADD;
      CMD_SUB: a = ALU_SUB;
      CMD_AND: a = ALU_AND;
      CMD_ORR: a = ALU_ORR;
      CMD_EOR: a = ALU_EOR;
      CMD_MOV: a = ALU_MOV;
      CMD_CMP: a = ALU_CMP;
      CMD_TST: a = ALU_TST;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/arm_multi_ctrl_if.sv
// Control/datapath bundle between the sequencer and the multicycle datapath.
// master = sequencer side, slave = datapath/memory side.
interface arm_multi_ctrl_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic        mem_req;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic [1:0]  RegSrc;
  logic [1:0]  ImmSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic [1:0]  ResultSrc;
  logic [3:0]  Flags;
  logic        illegal;

  modport master (
    input  Instr, ALUFlags, mem_ready,
    output mem_req, AdrSrc, MemWrite,
    output IRWrite, PCWrite, RegWrite,
    output RegSrc, ImmSrc, ALUSrcA,
    output ALUSrcB, ALUControl, ResultSrc,
    output Flags, illegal
  );

  modport slave (
    output Instr, ALUFlags, mem_ready,
    input  mem_req, AdrSrc, MemWrite,
    input  IRWrite, PCWrite, RegWrite,
    input  RegSrc, ImmSrc, ALUSrcA,
    input  ALUSrcB, ALUControl, ResultSrc,
    input  Flags, illegal
  );
endinterface

// File: rtl/arm_multi_condunit.sv
// NZCV flag register, condition evaluation and the per-instruction
// latched condition result used to qualify the later flag write.
module arm_multi_condunit
  import arm_multi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_cond,
  input  logic       i_latch,
  input  logic       i_nz_w,
  input  logic       i_cv_w,
  input  logic [3:0] i_alu_flags,
  output logic [3:0] o_flags,
  output logic       o_cond_ex,
  output logic       o_cond_q
);

  logic [3:0] r_flags;
  logic       r_cond_q;
  logic       w_cond_ex;

  assign w_cond_ex = cond_holds(i_cond, r_flags);
  assign o_cond_ex = w_cond_ex;
  assign o_cond_q  = r_cond_q;
  assign o_flags   = r_flags;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags  <= 4'b0000;
      r_cond_q <= 1'b0;
    end else begin
      if (i_latch)
        r_cond_q <= w_cond_ex;
      if (i_nz_w)
        r_flags[3:2] <= i_alu_flags[3:2];
      if (i_cv_w)
        r_flags[1:0] <= i_alu_flags[1:0];
    end
  end

endmodule

// File: rtl/arm_multi_ctrl.sv
// Multicycle ARMv4-subset control sequencer: decodes the IR, steps
// the per-instruction state machine and drives datapath selects/strobes.
module arm_multi_ctrl
  import arm_multi_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  arm_multi_ctrl_if.master bus
);

  state_t     r_state;
  state_t     w_next;

  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;
  logic [2:0] w_alu_op;
  logic       w_cmp_tst;
  logic       w_rd15;
  logic       w_unused;

  logic       w_cond_ex;
  logic       w_cond_q;
  logic [3:0] w_flags;

  logic       w_mem_req;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_reg_write;
  logic [1:0] w_reg_src;
  logic [1:0] w_imm_src;
  logic       w_src_a;
  logic [1:0] w_src_b;
  logic [2:0] w_alu_ctl;
  logic [1:0] w_res_src;
  logic       w_illegal;
  logic       w_latch;
  logic       w_nz_w;
  logic       w_cv_w;

  assign w_cond    = bus.Instr[19:16];
  assign w_op      = bus.Instr[15:14];
  assign w_funct   = bus.Instr[13:8];
  assign w_rd      = bus.Instr[3:0];
  assign w_unused  = ^bus.Instr[7:4];
  assign w_alu_op  = alu_decode(w_funct[4:1]);
  assign w_rd15    = (w_rd == 4'hF);
  assign w_cmp_tst = (w_funct[4:1] == CMD_CMP)
                   | (w_funct[4:1] == CMD_TST);

  arm_multi_condunit u_cond (
    .clk         (clk),
    .reset       (reset),
    .i_cond      (w_cond),
    .i_latch     (w_latch),
    .i_nz_w      (w_nz_w),
    .i_cv_w      (w_cv_w),
    .i_alu_flags (bus.ALUFlags),
    .o_flags     (w_flags),
    .o_cond_ex   (w_cond_ex),
    .o_cond_q    (w_cond_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_FETCH;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_adr_src   = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    w_reg_src   = 2'b00;
    w_imm_src   = IMM_8;
    w_src_a     = 1'b0;
    w_src_b     = SRCB_REG;
    w_alu_ctl   = ALU_ADD;
    w_res_src   = RES_ALUOUT;
    w_illegal   = 1'b0;
    w_latch     = 1'b0;
    w_nz_w      = 1'b0;
    w_cv_w      = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_src_a   = 1'b1;
        w_src_b   = SRCB_FOUR;
        w_res_src = RES_ALURES;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_src_a   = 1'b1;
        w_src_b   = SRCB_FOUR;
        w_res_src = RES_ALURES;
        w_latch   = 1'b1;
        if (!w_cond_ex) begin
          w_next = S_FETCH;
        end else begin
          unique case (1'b1)
            (w_op == OP_MEM):
              w_next = S_MEMADR;
            (w_op == OP_DP) && w_funct[5]:
              w_next = S_EXECI;
            (w_op == OP_DP) && !w_funct[5]:
              w_next = S_EXECR;
            (w_op == OP_BR):
              w_next = S_BRANCH;
            (w_op == OP_ILL):
              w_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
            default:
              w_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        w_src_b   = SRCB_IMM;
        w_imm_src = IMM_12;
        w_next    = w_funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (bus.mem_ready)
          w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_res_src   = RES_DATA;
        w_reg_write = 1'b1;
        w_pc_write  = w_rd15;
        w_next      = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
        w_reg_src   = 2'b10;
        if (bus.mem_ready)
          w_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        w_src_b   = (r_state == S_EXECI) ? SRCB_IMM
                                         : SRCB_REG;
        w_alu_ctl = w_alu_op;
        // CMP/TST always set flags; C,V only from arithmetic ops
        w_nz_w    = w_cond_q & (w_funct[0] | w_cmp_tst);
        w_cv_w    = w_nz_w & ((w_alu_op == ALU_ADD)
                            | (w_alu_op == ALU_SUB)
                            | (w_alu_op == ALU_CMP));
        w_next    = w_cmp_tst ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_pc_write  = w_rd15;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_src_b    = SRCB_IMM;
        w_imm_src  = IMM_24;
        w_res_src  = RES_ALURES;
        w_pc_write = 1'b1;
        w_next     = S_FETCH;
      end
      S_TRAP: begin
        w_illegal = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // strobes are masked combinationally so reset drops them at once
  assign bus.mem_req    = w_mem_req & reset;
  assign bus.MemWrite   = w_mem_write & reset;
  assign bus.IRWrite    = w_ir_write & reset;
  assign bus.PCWrite    = w_pc_write & reset;
  assign bus.RegWrite   = w_reg_write & reset;
  assign bus.illegal    = w_illegal & reset;
  assign bus.AdrSrc     = w_adr_src;
  assign bus.RegSrc     = w_reg_src;
  assign bus.ImmSrc     = w_imm_src;
  assign bus.ALUSrcA    = w_src_a;
  assign bus.ALUSrcB    = w_src_b;
  assign bus.ALUControl = w_alu_ctl;
  assign bus.ResultSrc  = w_res_src;
  assign bus.Flags      = w_flags;

endmodule

// File: tb/tb_arm_multi_ctrl.sv
// Self-checking bench for arm_multi_ctrl: per-cycle expected output
// vectors are queued with the stimulus and popped as the FSM steps.
module tb_arm_multi_ctrl;

  logic clk;
  logic reset;
  int   n_err;
  int   n_chk;

  logic        q_rdy[$];
  logic [18:0] q_exp[$];
  logic [18:0] outs;

  arm_multi_ctrl_if bus ();

  arm_multi_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign outs = {bus.mem_req, bus.AdrSrc, bus.MemWrite,
                 bus.IRWrite, bus.PCWrite, bus.RegWrite,
                 bus.RegSrc, bus.ImmSrc, bus.ALUSrcA,
                 bus.ALUSrcB, bus.ALUControl,
                 bus.ResultSrc, bus.illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  function automatic logic [18:0] ov(
    input logic mreq, input logic adr, input logic mw,
    input logic irw, input logic pcw, input logic rw,
    input logic [1:0] rs, input logic [1:0] imm,
    input logic sa, input logic [1:0] sb,
    input logic [2:0] alu, input logic [1:0] res,
    input logic ill
  );
    return {mreq, adr, mw, irw, pcw, rw, rs, imm,
            sa, sb, alu, res, ill};
  endfunction

  function automatic logic [18:0] e_fetch(input logic r);
    return ov(1,0,0,r,r,0,2'b00,2'b00,1,2'b10,3'd0,2'b10,0);
  endfunction
  function automatic logic [18:0] e_rst();
    return ov(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,3'd0,2'b10,0);
  endfunction
  function automatic logic [18:0] e_dec();
    return ov(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,3'd0,2'b10,0);
  endfunction
  function automatic logic [18:0] e_madr();
    return ov(0,0,0,0,0,0,2'b00,2'b01,0,2'b01,3'd0,2'b00,0);
  endfunction
  function automatic logic [18:0] e_mrd();
    return ov(1,1,0,0,0,0,2'b00,2'b00,0,2'b00,3'd0,2'b00,0);
  endfunction
  function automatic logic [18:0] e_mwb(input logic pc);
    return ov(0,0,0,0,pc,1,2'b00,2'b00,0,2'b00,3'd0,2'b01,0);
  endfunction
  function automatic logic [18:0] e_mwr();
    return ov(1,1,1,0,0,0,2'b10,2'b00,0,2'b00,3'd0,2'b00,0);
  endfunction
  function automatic logic [18:0] e_exec(
    input logic imm, input logic [2:0] alu
  );
    return ov(0,0,0,0,0,0,2'b00,2'b00,0,
              imm ? 2'b01 : 2'b00,alu,2'b00,0);
  endfunction
  function automatic logic [18:0] e_aluwb(input logic pc);
    return ov(0,0,0,0,pc,1,2'b00,2'b00,0,2'b00,3'd0,2'b00,0);
  endfunction
  function automatic logic [18:0] e_br();
    return ov(0,0,0,0,1,0,2'b00,2'b10,0,2'b01,3'd0,2'b10,0);
  endfunction
  function automatic logic [18:0] e_trap();
    return ov(0,0,0,0,0,0,2'b00,2'b00,0,2'b00,3'd0,2'b00,1);
  endfunction

  task automatic push(input logic r, input logic [18:0] e);
    q_rdy.push_back(r);
    q_exp.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.Instr = 20'h0;
    bus.ALUFlags = 4'b1111;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (outs !== e_rst()) begin
      n_err++;
      $display("FAIL reset_outs got %b want %b",
               outs, e_rst());
    end
    n_chk++;
    if (bus.Flags !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags got %b want 0000", bus.Flags);
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_add_imm();
    logic [18:0] want;
    int cyc;
    bus.Instr = 20'hE2800;
    bus.ALUFlags = 4'b1111;
    push(1, e_fetch(1));
    push(1, e_dec());
    push(1, e_exec(1, 3'b000));
    push(1, e_aluwb(0));
    cyc = 0;
    while (q_exp.size() > 0) begin
      bus.mem_ready = q_rdy.pop_front();
      @(negedge clk);
      want = q_exp.pop_front();
      n_chk++;
      if (outs !== want) begin
        n_err++;
        $display("FAIL add_imm c%0d got %b want %b",
                 cyc, outs, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (bus.Flags !== 4'b0000) begin
      n_err++;
      $display("FAIL add_imm_flags got %b want 0000", bus.Flags);
    end
  endtask

  task automatic test_ldr_wait();
    logic [18:0] want;
    int cyc;
    bus.Instr = 20'hE5901;
    push(1, e_fetch(1));
    push(1, e_dec());
    push(1, e_madr());
    repeat (3) push(0, e_mrd());
    push(1, e_mrd());
    push(1, e_mwb(0));
    cyc = 0;
    while (q_exp.size() > 0) begin
      bus.mem_ready = q_rdy.pop_front();
      @(negedge clk);
      want = q_exp.pop_front();
      n_chk++;
      if (outs !== want) begin
        n_err++;
        $display("FAIL ldr_wait c%0d got %b want %b",
                 cyc, outs, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_str_fetch_stall();
    logic [18:0] want;
    int cyc;
    bus.Instr = 20'hE5801;
    push(0, e_fetch(0));
    push(0, e_fetch(0));
    push(1, e_fetch(1));
    push(1, e_dec());
    push(1, e_madr());
    push(1, e_mwr());
    cyc = 0;
    while (q_exp.size() > 0) begin
      bus.mem_ready = q_rdy.pop_front();
      @(negedge clk);
      want = q_exp.pop_front();
      n_chk++;
      if (outs !== want) begin
        n_err++;
        $display("FAIL str c%0d got %b want %b",
                 cyc, outs, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_subs_beq_bne();
    logic [18:0] want;
    int cyc;
    bus.Instr = 20'hE2500;
    bus.ALUFlags = 4'b0100;
    push(1, e_fetch(1));
    push(1, e_dec());
    push(1, e_exec(1, 3'b001));
    push(1, e_aluwb(0));
    cyc = 0;
    while (q_exp.size() > 0) begin
      bus.mem_ready = q_rdy.pop_front();
      @(negedge clk);
      want = q_exp.pop_front();
      n_chk++;
      if (outs !== want) begin
        n_err++;
        $display("FAIL subs c%0d got %b want %b",
                 cyc, outs, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (bus.Flags !== 4'b0100) begin
      n_err++;
      $display("FAIL subs_flags got %b want 0100", bus.Flags);
    end
    bus.Instr = 20'h0A000;
    bus.ALUFlags = 4'b1011;
    push(1, e_fetch(1));
    push(1, e_dec());
    push(1, e_br());
    cyc = 0;
    while (q_exp.size() > 0) begin
      bus.mem_ready = q_rdy.pop_front();
      @(negedge clk);
      want = q_exp.pop_front();
      n_chk++;
      if (outs !== want) begin
        n_err++;
        $display("FAIL beq c%0d got %b want %b",
                 cyc, outs, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
    bus.Instr = 20'h1A000;
    push(1, e_fetch(1));
    push(1, e_dec());
    push(0, e_fetch(0));
    cyc = 0;
    while (q_exp.size() > 0) begin
      bus.mem_ready = q_rdy.pop_front();
      @(negedge clk);
      want = q_exp.pop_front();
      n_chk++;
      if (outs !== want) begin
        n_err++;
        $display("FAIL bne c%0d got %b want %b",
                 cyc, outs, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (bus.Flags !== 4'b0100) begin
      n_err++;
      $display("FAIL br_flags got %b want 0100", bus.Flags);
    end
  endtask

  task automatic test_cmp_tst();
    logic [18:0] want;
    int cyc;
    bus.Instr = 20'hE1510;
    bus.ALUFlags = 4'b0110;
    push(1, e_fetch(1));
    push(1, e_dec());
    push(1, e_exec(0, 3'b110));
    cyc = 0;
    while (q_exp.size() > 0) begin
      bus.mem_ready = q_rdy.pop_front();
      @(negedge clk);
      want = q_exp.pop_front();
      n_chk++;
      if (outs !== want) begin
        n_err++;
        $display("FAIL cmp c%0d got %b want %b",
                 cyc, outs, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (bus.Flags !== 4'b0110) begin
      n_err++;
      $display("FAIL cmp_flags got %b want 0110", bus.Flags);
    end
    bus.Instr = 20'hE1010;
    bus.ALUFlags = 4'b1001;
    push(1, e_fetch(1));
    push(1, e_dec());
    push(1, e_exec(0, 3'b111));
    cyc = 0;
    while (q_exp.size() > 0) begin
      bus.mem_ready = q_rdy.pop_front();
      @(negedge clk);
      want = q_exp.pop_front();
      n_chk++;
      if (outs !== want) begin
        n_err++;
        $display("FAIL tst c%0d got %b want %b",
                 cyc, outs, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (bus.Flags !== 4'b1010) begin
      n_err++;
      $display("FAIL tst_flags got %b want 1010", bus.Flags);
    end
  endtask

  task automatic test_pc_write();
    logic [18:0] want;
    int cyc;
    bus.Instr = 20'hE080F;
    bus.ALUFlags = 4'b1111;
    push(1, e_fetch(1));
    push(1, e_dec());
    push(1, e_exec(0, 3'b000));
    push(1, e_aluwb(1));
    cyc = 0;
    while (q_exp.size() > 0) begin
      bus.mem_ready = q_rdy.pop_front();
      @(negedge clk);
      want = q_exp.pop_front();
      n_chk++;
      if (outs !== want) begin
        n_err++;
        $display("FAIL add_pc c%0d got %b want %b",
                 cyc, outs, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (bus.Flags !== 4'b1010) begin
      n_err++;
      $display("FAIL add_pc_flags got %b want 1010", bus.Flags);
    end
  endtask

  task automatic test_reset_mid_illegal();
    logic [18:0] want;
    int cyc;
    bus.Instr = 20'hE5801;
    push(1, e_fetch(1));
    push(1, e_dec());
    push(1, e_madr());
    push(0, e_mwr());
    push(0, e_mwr());
    cyc = 0;
    while (q_exp.size() > 0) begin
      bus.mem_ready = q_rdy.pop_front();
      @(negedge clk);
      want = q_exp.pop_front();
      n_chk++;
      if (outs !== want) begin
        n_err++;
        $display("FAIL str_wait c%0d got %b want %b",
                 cyc, outs, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    #1;
    n_chk++;
    if ({bus.mem_req, bus.MemWrite} !== 2'b11) begin
      n_err++;
      $display("FAIL pre_reset_wr got %b want 11",
               {bus.mem_req, bus.MemWrite});
    end
    reset = 1'b0;
    #1;
    n_chk++;
    if (outs !== e_rst()) begin
      n_err++;
      $display("FAIL mid_reset got %b want %b",
               outs, e_rst());
    end
    @(negedge clk);
    n_chk++;
    if (bus.Flags !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_reset_flags got %b want 0000",
               bus.Flags);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    bus.Instr = 20'hEC000;
    push(0, e_fetch(0));
    push(1, e_fetch(1));
    push(1, e_dec());
    push(1, e_trap());
    push(0, e_trap());
    push(1, e_trap());
    cyc = 0;
    while (q_exp.size() > 0) begin
      bus.mem_ready = q_rdy.pop_front();
      @(negedge clk);
      want = q_exp.pop_front();
      n_chk++;
      if (outs !== want) begin
        n_err++;
        $display("FAIL illegal c%0d got %b want %b",
                 cyc, outs, want);
      end
      cyc++;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    n_chk++;
    if (bus.illegal !== 1'b0) begin
      n_err++;
      $display("FAIL trap_reset got %b want 0", bus.illegal);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (outs !== e_fetch(0)) begin
      n_err++;
      $display("FAIL after_trap got %b want %b",
               outs, e_fetch(0));
    end
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    test_reset();
    test_add_imm();
    test_ldr_wait();
    test_str_fetch_stall();
    test_subs_beq_bne();
    test_cmp_tst();
    test_pc_write();
    test_reset_mid_illegal();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
